tile_inject_port: RTL
=====================

# tile_inject_port

Parametrised injection port between a tile's endpoint and its local switch input. It buffers outbound flits per virtual channel (VC) and arbitrates round-robin among VCs that hold data and downstream credit. It issues at most one flit per cycle and tracks credit-based flow control toward the switch buffer. It generalises the tile's fixed two-VC, fixed-depth injection path to any VC count, FIFO depth and credit budget.

## Interface
Parameters:
- NUM_VCS, 2, number of virtual channels (≥1)
- DATA_WIDTH, 32, flit width in bits
- DEPTH, 8, per-VC FIFO entries (power of two, ≥2)
- CREDITS, 8, downstream buffer slots per VC (initial credit count)

Ports (all synchronous to clk; reset is asynchronous and active-low on n_rst):
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- in_valid  in  NUM_VCS  per-VC flit offered by endpoint
- in_ready  out  NUM_VCS  per-VC FIFO not full
- in_data  in  NUM_VCS*DATA_WIDTH  per-VC flit; VC i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  NUM_VCS  per-VC tail-flit marker
- out_valid  out  1  flit on out_data this cycle
- out_vc  out  $clog2(NUM_VCS) (min 1)  VC of the output flit
- out_data  out  DATA_WIDTH  output flit
- out_last  out  1  output flit is a tail
- credit_return  in  NUM_VCS  one-cycle pulse; returns one credit to that VC
- credit_err  out  1  sticky; set on credit overflow

## Operation
- Enqueue: VC i writes {in_data, in_last} when in_valid[i] && in_ready[i]. in_ready[i] = FIFO i not full. It is combinational from registered occupancy only and never depends on in_valid.
- Eligibility: VC i is eligible when FIFO i is non-empty and credit[i] > 0.
- Arbitration: round-robin. The search starts at VC (last_grant+1) mod NUM_VCS. last_grant resets to NUM_VCS-1, so VC0 has first priority.
- Grant: the granted VC pops one flit, and credit[i] decrements by 1. The flit is registered onto out_* in the next cycle.
- Credits: each counter is $clog2(CREDITS+1) bits.
  - Grant and credit_return to the same VC in the same cycle: the count is unchanged.
  - credit_return while credit[i] == CREDITS with no grant: the count saturates and credit_err is set.
  - credit_err clears only on reset.
- Empty FIFO: a pop never occurs. An in_valid with in_ready low is ignored, and the producer must hold the flit.
- Full FIFO: a write and a pop in the same cycle to a full FIFO are impossible, because in_ready is low. A write and a pop on a non-full FIFO in the same cycle leaves occupancy unchanged.
- Pointers: wrap modulo DEPTH. Occupancy is counted with $clog2(DEPTH)+1 bits.
- Reset: asynchronous, at any time, including mid-packet. Every FIFO empties and its pointers clear. Every credit returns to CREDITS. The packet lock clears. Flits in flight are discarded.
- Reset output values: out_valid=0, out_vc=0, out_data=0, out_last=0, credit_err=0, in_ready=all 1s.

## Timing
- Flit written at edge N into an empty FIFO (with credit available) is eligible in cycle N+1 and appears on out_* during cycle N+2 (2-cycle latency).
- Throughput: 1 flit/cycle total with sustained credit.
- out_valid is high for exactly one cycle per flit. There is no output backpressure; credits alone govern flow.
- out_vc/out_data/out_last hold their last value when out_valid=0.
- A credit_return at edge N makes its VC eligible for grant in cycle N+1.

## Configuration
- TILE_INJ_PKT_LOCK_EN defined (wormhole mode):
  - After granting a non-tail flit from VC i, the arbiter grants only VC i until its in_last flit has been granted.
  - While locked and VC i is ineligible, no flit issues.
  - The round-robin pointer advances only on the tail grant.
- TILE_INJ_PKT_LOCK_EN undefined (flit interleave):
  - Every cycle is an independent round-robin grant.
  - The pointer advances on every grant, and flits of different packets interleave.

## Test plan
- Reset, then one flit 0xDEADBEEF (last=1) on VC1 at cycle 0 -> out_valid at cycle 2, out_vc=1, out_data=0xDEADBEEF, out_last=1. credit[1]=CREDITS-1.
- VC0 and VC1 each load 3 flits simultaneously, lock macro off -> output VC order 0,1,0,1,0,1, one flit per cycle.
- Same stimulus with TILE_INJ_PKT_LOCK_EN, tail on the 3rd flit -> order 0,0,0,1,1,1. A VC1 flit never appears mid VC0 packet, even when VC0 stalls for 2 cycles on empty.
- CREDITS=8, push 10 flits on VC0, no returns -> exactly 8 output. Pulse credit_return[0] twice -> remaining 2 issue. credit_err stays 0.
- Fill VC0 to DEPTH=8 with no credits -> in_ready[0]=0 and a 9th offered flit is not accepted. Assert n_rst mid-packet -> all outputs at reset values, in_ready all 1, credits restored to 8.
- credit_return[0] with credit[0]=CREDITS -> credit_err=1 next cycle, count stays 8. credit_err remains 1 until reset.

Source files
------------

// File: rtl/tile_inject_port.sv
`default_nettype none
// ============================================================================
// Module  : tile_inject_port
// Brief   : Per-VC flit FIFOs feeding a credit-gated round-robin injector.
//           Define TILE_INJ_PKT_LOCK_EN for wormhole (packet-locked) arbitration.
// Revision: 1.0  initial release
// ============================================================================
module tile_inject_port #(
    parameter int NUM_VCS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CREDITS    = 8,
    localparam int C_VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [NUM_VCS-1:0]            in_valid,
    output logic [NUM_VCS-1:0]            in_ready,
    input  logic [NUM_VCS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_VCS-1:0]            in_last,
    output logic                          out_valid,
    output logic [C_VC_W-1:0]             out_vc,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    input  logic [NUM_VCS-1:0]            credit_return,
    output logic                          credit_err
);

    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_OCC_W = C_PTR_W + 1;
    localparam int C_CRD_W = $clog2(CREDITS + 1);
    localparam logic [C_OCC_W-1:0] C_FULL    = C_OCC_W'(DEPTH);
    localparam logic [C_CRD_W-1:0] C_CRD_MAX = C_CRD_W'(CREDITS);

    // Entry layout: {last, data}
    logic [DATA_WIDTH:0]   fifo_mem [NUM_VCS][DEPTH];
    logic [C_PTR_W-1:0]    wr_ptr_q [NUM_VCS];
    logic [C_PTR_W-1:0]    wr_ptr_d [NUM_VCS];
    logic [C_PTR_W-1:0]    rd_ptr_q [NUM_VCS];
    logic [C_PTR_W-1:0]    rd_ptr_d [NUM_VCS];
    logic [C_OCC_W-1:0]    occ_q    [NUM_VCS];
    logic [C_OCC_W-1:0]    occ_d    [NUM_VCS];
    logic [C_CRD_W-1:0]    credit_q [NUM_VCS];
    logic [C_CRD_W-1:0]    credit_d [NUM_VCS];
    logic [C_VC_W-1:0]     last_grant_q, last_grant_d;
    logic                  out_valid_q, out_valid_d;
    logic [C_VC_W-1:0]     out_vc_q, out_vc_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  credit_err_q, credit_err_d;
`ifdef TILE_INJ_PKT_LOCK_EN
    logic                  lock_q, lock_d;
    logic [C_VC_W-1:0]     lock_vc_q, lock_vc_d;
`endif

    logic [NUM_VCS-1:0]    w_push, w_pop, w_elig;
    logic                  w_gnt;
    logic [C_VC_W-1:0]     w_gnt_vc, w_cand;
    logic [DATA_WIDTH:0]   w_head;

    for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
        assign in_ready[gi] = (occ_q[gi] != C_FULL);
        assign w_push[gi]   = in_valid[gi] && in_ready[gi];
        assign w_elig[gi]   = (occ_q[gi] != '0) && (credit_q[gi] != '0);
        assign w_pop[gi]    = w_gnt && (w_gnt_vc == C_VC_W'(gi));
    end

    // Round-robin search from the VC after the last pointer position.
    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_vc = '0;
        w_cand   = '0;
        for (int off = 1; off <= NUM_VCS; off++) begin
            w_cand = C_VC_W'((int'(last_grant_q) + off) % NUM_VCS);
            if (!w_gnt && w_elig[w_cand]) begin
                w_gnt    = 1'b1;
                w_gnt_vc = w_cand;
            end
        end
`ifdef TILE_INJ_PKT_LOCK_EN
        if (lock_q) begin
            w_gnt    = w_elig[lock_vc_q];
            w_gnt_vc = lock_vc_q;
        end
`endif
    end

    assign w_head = fifo_mem[w_gnt_vc][rd_ptr_q[w_gnt_vc]];

    always_comb begin
        credit_err_d = credit_err_q;
        for (int i = 0; i < NUM_VCS; i++) begin
            wr_ptr_d[i] = w_push[i] ? wr_ptr_q[i] + C_PTR_W'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = w_pop[i]  ? rd_ptr_q[i] + C_PTR_W'(1) : rd_ptr_q[i];
            case ({w_push[i], w_pop[i]})
                2'b10:   occ_d[i] = occ_q[i] + C_OCC_W'(1);
                2'b01:   occ_d[i] = occ_q[i] - C_OCC_W'(1);
                default: occ_d[i] = occ_q[i];
            endcase
            credit_d[i] = credit_q[i];
            case ({w_pop[i], credit_return[i]})
                2'b10: credit_d[i] = credit_q[i] - C_CRD_W'(1);
                2'b01: begin
                    if (credit_q[i] == C_CRD_MAX) credit_err_d = 1'b1;
                    else                          credit_d[i]  = credit_q[i] + C_CRD_W'(1);
                end
                default: credit_d[i] = credit_q[i];
            endcase
        end
    end

    always_comb begin
        out_valid_d  = w_gnt;
        out_vc_d     = w_gnt ? w_gnt_vc : out_vc_q;
        out_data_d   = w_gnt ? w_head[DATA_WIDTH-1:0] : out_data_q;
        out_last_d   = w_gnt ? w_head[DATA_WIDTH] : out_last_q;
        last_grant_d = last_grant_q;
`ifdef TILE_INJ_PKT_LOCK_EN
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        // Pointer moves only when a packet completes; a head flit locks its VC.
        if (w_gnt) begin
            if (w_head[DATA_WIDTH]) begin
                lock_d       = 1'b0;
                last_grant_d = w_gnt_vc;
            end else begin
                lock_d    = 1'b1;
                lock_vc_d = w_gnt_vc;
            end
        end
`else
        if (w_gnt) last_grant_d = w_gnt_vc;
`endif
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VCS; i++) begin
            if (w_push[i]) fifo_mem[i][wr_ptr_q[i]] <= {in_last[i], in_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_VCS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
                credit_q[i] <= C_CRD_MAX;
            end
            last_grant_q <= C_VC_W'(NUM_VCS - 1);
            out_valid_q  <= 1'b0;
            out_vc_q     <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            credit_err_q <= 1'b0;
`ifdef TILE_INJ_PKT_LOCK_EN
            lock_q       <= 1'b0;
            lock_vc_q    <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            credit_q     <= credit_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_vc_q     <= out_vc_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            credit_err_q <= credit_err_d;
`ifdef TILE_INJ_PKT_LOCK_EN
            lock_q       <= lock_d;
            lock_vc_q    <= lock_vc_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_vc     = out_vc_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign credit_err = credit_err_q;

endmodule
`default_nettype wire
